booth_r4_seq_mult: RTL and testbench

Parametrised, iterative radix-4 Booth multiplier that retires one Booth digit per clock cycle. It generalises the combinational Booth digit encoding to any even operand width, selects signed or unsigned operation per transaction, and accumulates the partial products internally. It sits between an operand producer and a result consumer, each connected through a valid/ready handshake. It is the area-optimised alternative to the fully parallel partial-product array.

---
 rtl/booth_r4_seq_mult.sv | 86 ++++++++
 tb/tb_booth_r4_seq_mult.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/booth_r4_seq_mult.sv
// booth_r4_seq_mult: iterative radix-4 Booth multiplier, one digit per cycle, valid/ready on both sides.
// Define BOOTH_EARLY_TERM_EN to finish as soon as all remaining Booth digits are zero.
module booth_r4_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [WIDTH-1:0]   i_multiplicand,
  input  logic [WIDTH-1:0]   i_multiplier,
  input  logic               i_signed_mpy,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [2*WIDTH-1:0] o_product,
  output logic               o_busy
);
  localparam int D  = WIDTH / 2 + 1;
  localparam int IW = $clog2(D);
  localparam int AW = 2 * WIDTH + 2;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  state_t             r_state, w_next;
  logic [WIDTH-1:0]   r_a, r_b;
  logic               r_sgn;
  logic [AW-1:0]      r_acc;
  logic [IW-1:0]      r_idx;
  logic [2*WIDTH-1:0] r_prod;
  logic               w_ext, w_last, w_accept;
  logic [WIDTH+2:0]   w_b;
  logic [2:0]         w_t;
  logic [AW-1:0]      w_a_ext, w_mag, w_pp, w_sum;
  assign w_ext    = r_sgn & r_b[WIDTH-1];
  assign w_b      = {w_ext, w_ext, r_b, 1'b0};
  assign w_t      = w_b[2*r_idx +: 3];
  assign w_a_ext  = {{(AW-WIDTH){r_sgn & r_a[WIDTH-1]}}, r_a};
  assign w_mag    = (w_t[0] ^ w_t[1]) ? w_a_ext :
                    (w_t == 3'b011 || w_t == 3'b100) ? (w_a_ext << 1) : '0;
  assign w_pp     = w_t[2] ? -w_mag : w_mag;
  assign w_sum    = r_acc + (w_pp << (2*r_idx));
  assign w_accept = i_in_valid & o_in_ready;
`ifdef BOOTH_EARLY_TERM_EN
  logic [WIDTH+2:0] w_rest;
  // arithmetic shift keeps the top bit, so "rest is all zeros or all ones" reduces to two compares
  assign w_rest = $signed(w_b) >>> (2*r_idx + 2);
  assign w_last = (r_idx == IW'(D-1)) | (w_rest == '0) | (&w_rest);
`else
  assign w_last = r_idx == IW'(D-1);
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_accept ? S_CALC : S_IDLE;
      S_CALC:  w_next = w_last ? S_DONE : S_CALC;
      S_DONE:  w_next = i_out_ready ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sgn   <= 1'b0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_prod  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a   <= i_multiplicand;
        r_b   <= i_multiplier;
        r_sgn <= i_signed_mpy;
        r_acc <= '0;
        r_idx <= '0;
      end else if (r_state == S_CALC) begin
        r_acc <= w_sum;
        r_idx <= r_idx + 1'b1;
        if (w_last) r_prod <= w_sum[2*WIDTH-1:0];
      end
    end
  end
  assign o_in_ready  = r_state == S_IDLE;
  assign o_out_valid = r_state == S_DONE;
  assign o_busy      = r_state != S_IDLE;
  assign o_product   = r_prod;
endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// tb_booth_r4_seq_mult: directed vector table plus handshake, back-pressure and reset sequences.
module tb_booth_r4_seq_mult;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, busy, sgn = 1'b0;
  logic [7:0]  mcand = '0, mplier = '0;
  logic [15:0] product;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  booth_r4_seq_mult #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_multiplicand(mcand), .i_multiplier(mplier), .i_signed_mpy(sgn),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_product(product), .o_busy(busy)
  );
  typedef struct {
    logic        s;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[10];
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    end
  endtask
  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
  endtask
  task automatic txn(input logic s, input logic [7:0] a, input logic [7:0] b,
                     output logic [15:0] p, output int lat);
    @(negedge clk);
    sgn = s; mcand = a; mplier = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(lat);
    p = product;
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("in_ready_after_handshake", {31'b0, in_ready}, 32'd1);
  endtask
  initial begin
    logic [15:0] p, m;
    logic signed [15:0] sp;
    int lat;
    vecs[0] = '{1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[1] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{1'b0, 8'h80, 8'hFF, 16'h7F80};
    vecs[3] = '{1'b1, 8'h07, 8'hFD, 16'hFFEB};
    vecs[4] = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};
    vecs[5] = '{1'b0, 8'h00, 8'hAB, 16'h0000};
    vecs[6] = '{1'b1, 8'h7F, 8'h80, 16'hC080};
    vecs[7] = '{1'b0, 8'h80, 8'h80, 16'h4000};
    vecs[8] = '{1'b1, 8'h64, 8'h64, 16'h2710};
    vecs[9] = '{1'b0, 8'h0C, 8'h0D, 16'h009C};
    #12;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_product", {16'b0, product}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      txn(vecs[i].s, vecs[i].a, vecs[i].b, p, lat);
      check($sformatf("vec%0d_product", i), {16'b0, p}, {16'b0, vecs[i].exp});
`ifndef BOOTH_EARLY_TERM_EN
      check($sformatf("vec%0d_latency", i), lat, 32'd5);
`endif
    end
    for (int i = 0; i < 200; i++) begin
      logic [7:0] a, b;
      logic s;
      a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
      sp = $signed(a) * $signed(b);
      m = s ? sp : {8'b0, a} * {8'b0, b};
      txn(s, a, b, p, lat);
      check($sformatf("rand_s%0d_%0h_x_%0h", s, a, b), {16'b0, p}, {16'b0, m});
    end
`ifdef BOOTH_EARLY_TERM_EN
    txn(1'b0, 8'h09, 8'h01, p, lat);
    check("et_b1_latency", lat, 32'd1);
    check("et_b1_product", {16'b0, p}, 32'h0009);
    txn(1'b0, 8'h03, 8'h7F, p, lat);
    check("et_b7f_latency", lat, 32'd4);
    check("et_b7f_product", {16'b0, p}, 32'h017D);
    txn(1'b1, 8'h05, 8'hFF, p, lat);
    check("et_bm1_latency", lat, 32'd1);
    check("et_bm1_product", {16'b0, p}, 32'hFFFB);
`endif
    // back-pressure with in_valid kept high and new operands waiting
    @(negedge clk);
    sgn = 1'b0; mcand = 8'd12; mplier = 8'd13; in_valid = 1'b1;
    @(posedge clk); #1;
    mcand = 8'd2; mplier = 8'd2;
    check("bp_busy", {31'b0, busy}, 32'd1);
    wait_done(lat);
    check("bp_product_first", {16'b0, product}, 32'h009C);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check("bp_product_hold", {16'b0, product}, 32'h009C);
      check("bp_out_valid_hold", {31'b0, out_valid}, 32'd1);
      check("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_idle_in_ready", {31'b0, in_ready}, 32'd1);
    check("bp_idle_out_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_accepted", {31'b0, busy}, 32'd1);
    wait_done(lat);
    check("bp_next_product", {16'b0, product}, 32'h0004);
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    // asynchronous reset in the second CALC cycle
    @(negedge clk);
    sgn = 1'b1; mcand = 8'd100; mplier = 8'd100; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_product", {16'b0, product}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("post_rst_no_stale_valid", {31'b0, out_valid}, 32'd0);
    end
    txn(1'b0, 8'd3, 8'd5, p, lat);
    check("post_rst_product", {16'b0, p}, 32'h000F);
`ifndef BOOTH_EARLY_TERM_EN
    check("post_rst_latency", lat, 32'd5);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
